// File: rtl/snn_sched_pkg.sv
// Shared types and constants for the SNN window scheduler.
package snn_sched_pkg;

  // Scheduler phases: wait for a sample, hold the SNN in reset, integrate, present result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } sched_state_e;

  // Winner encodings presented on res_class.
  localparam logic [1:0] RES_CLASS_TIE = 2'b00;
  localparam logic [1:0] RES_CLASS_0   = 2'b01;
  localparam logic [1:0] RES_CLASS_1   = 2'b10;

  // Number of cycles the SNN is held in reset before a window when not overridden.
  localparam int DEFAULT_CLEAR_CYCLES = 2;

  // Map the outcome of comparing the two final counts to a class code.
  function automatic logic [1:0] class_from_cmp(input logic c0_greater, input logic c1_greater);
    logic [1:0] cls;
    cls = RES_CLASS_TIE;
    if (c0_greater) begin
      cls = RES_CLASS_0;
    end else if (c1_greater) begin
      cls = RES_CLASS_1;
    end
    return cls;
  endfunction

endpackage

// File: rtl/snn_spike_counter.sv
// Saturating spike counter with synchronous clear; stops at all-ones instead of wrapping.
module snn_spike_counter
  import snn_sched_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over increment, increment holds once saturated.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/snn_window_scheduler.sv
// Drives one sample into an SNN for a programmable window, counts per-class
// output spikes, and reports the winning class through a valid/ready handshake.
module snn_window_scheduler
  import snn_sched_pkg::*;
#(
  parameter int WINDOW_W     = 8,
  parameter int CNT_W        = 6,
  parameter int CLEAR_CYCLES = DEFAULT_CLEAR_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic                abort,
  output logic                snn_reset,
  output logic [7:0]          snn_input,
  input  logic [1:0]          snn_spikes,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CNT_W-1:0]    res_count0,
  output logic [CNT_W-1:0]    res_count1,
  output logic [1:0]          res_class,
  output logic                busy
);

  // One down-counter times both the CLEAR phase (up to 15 cycles) and the RUN window.
  localparam int TMR_W = (WINDOW_W > 4) ? WINDOW_W : 4;

  sched_state_e      state_q, state_d;
  logic [7:0]        input_q, input_d;
  logic [WINDOW_W-1:0] len_q, len_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              clear_cnt;
  logic              accept;
  logic              in_run;
  logic [CNT_W-1:0]  count0;
  logic [CNT_W-1:0]  count1;

  assign accept = in_valid && (state_q == IDLE);
  assign in_run = (state_q == RUN);

  // Next-state, latched sample/length, phase timer and counter clear.
  always_comb begin
    state_d   = state_q;
    input_d   = input_q;
    len_d     = len_q;
    tmr_d     = tmr_q;
    clear_cnt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          input_d   = in_data;
          len_d     = (window_len == '0) ? WINDOW_W'(1) : window_len;
          tmr_d     = TMR_W'(CLEAR_CYCLES - 1);
          clear_cnt = 1'b1;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tmr_q == '0) begin
          tmr_d   = TMR_W'(len_q - WINDOW_W'(1));
          state_d = RUN;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tmr_q == '0) begin
          state_d = REPORT;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      REPORT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, sample, length and timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      input_q <= '0;
      len_q   <= WINDOW_W'(1);
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      input_q <= input_d;
      len_q   <= len_d;
      tmr_q   <= tmr_d;
    end
  end

  snn_spike_counter #(
    .CNT_W (CNT_W)
  ) u_count0 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_cnt),
    .inc   (in_run && snn_spikes[0]),
    .count (count0)
  );

  snn_spike_counter #(
    .CNT_W (CNT_W)
  ) u_count1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_cnt),
    .inc   (in_run && snn_spikes[1]),
    .count (count1)
  );

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign snn_reset  = (state_q != RUN);
  assign res_valid  = (state_q == REPORT);
  assign snn_input  = input_q;
  assign res_count0 = count0;
  assign res_count1 = count1;
  assign res_class  = class_from_cmp(count0 > count1, count1 > count0);

endmodule

// File: tb/tb_snn_window_scheduler.sv
// Randomized and directed bench for snn_window_scheduler against a window-level model.
module tb_snn_window_scheduler;

  localparam int WW   = 8;
  localparam int CW   = 6;
  localparam int C    = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic [WW-1:0] window_len;
  logic          abort;
  logic          snn_reset;
  logic [7:0]    snn_input;
  logic [1:0]    snn_spikes;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_count0;
  logic [CW-1:0] res_count1;
  logic [1:0]    res_class;
  logic          busy;

  int numTests = 0;
  int numFails = 0;

  snn_window_scheduler #(
    .WINDOW_W     (WW),
    .CNT_W        (CW),
    .CLEAR_CYCLES (C)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .window_len (window_len),
    .abort      (abort),
    .snn_reset  (snn_reset),
    .snn_input  (snn_input),
    .snn_spikes (snn_spikes),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_count0 (res_count0),
    .res_count1 (res_count1),
    .res_class  (res_class),
    .busy       (busy)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numTests++;
    assert (observed === expected) else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int c);
    return (c > CMAX) ? CMAX : c;
  endfunction

  function automatic logic [1:0] winner(input int a, input int b);
    if (a > b) return 2'b01;
    if (b > a) return 2'b10;
    return 2'b00;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " in_ready"}, in_ready, 1);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " snn_reset"}, snn_reset, 1);
    checkOutput({tag, " res_valid"}, res_valid, 0);
    checkOutput({tag, " res_class"}, res_class, 0);
    checkOutput({tag, " count0"}, res_count0, 0);
    checkOutput({tag, " count1"}, res_count1, 0);
    checkOutput({tag, " snn_input"}, snn_input, 0);
  endtask

  // One transaction starting in IDLE at posedge+1. pat<0 gives random spikes;
  // abortAt is the cycle (1 = first after accept) in which abort is held, 0 for none.
  task automatic applyStimulus(input logic [7:0] data, input logic [WW-1:0] wlen, input int pat,
                               input int abortAt, input int readyDelay, input bit idleAbort);
    int L;
    int c0;
    int c1;
    int e0;
    int e1;
    L  = (wlen == 0) ? 1 : int'(wlen);
    c0 = 0;
    c1 = 0;
    checkOutput("idle in_ready", in_ready, 1);
    in_valid   = 1'b1;
    in_data    = data;
    window_len = wlen;
    abort      = idleAbort;
    res_ready  = 1'b0;
    snn_spikes = 2'($urandom);
    for (int k = 1; k <= C + L; k++) begin
      tick();
      in_valid   = 1'($urandom);
      in_data    = 8'($urandom);
      window_len = WW'($urandom);
      abort      = (k == abortAt);
      snn_spikes = (pat < 0) ? 2'($urandom) : 2'(pat);
      checkOutput("win res_valid", res_valid, 0);
      checkOutput("win in_ready", in_ready, 0);
      checkOutput("win busy", busy, 1);
      checkOutput("win snn_reset", snn_reset, (k <= C) ? 1 : 0);
      checkOutput("win snn_input", snn_input, data);
      if (k > C) begin
        c0 += int'(snn_spikes[0]);
        c1 += int'(snn_spikes[1]);
      end
      if (abort) begin
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        checkOutput("abort in_ready", in_ready, 1);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort snn_reset", snn_reset, 1);
        checkOutput("abort snn_input", snn_input, data);
        for (int j = 0; j < 3; j++) begin
          checkOutput("abort res_valid", res_valid, 0);
          tick();
        end
        return;
      end
    end
    tick();
    e0 = sat(c0);
    e1 = sat(c1);
    for (int d = 0; d <= readyDelay; d++) begin
      checkOutput("rep res_valid", res_valid, 1);
      checkOutput("rep in_ready", in_ready, 0);
      checkOutput("rep snn_reset", snn_reset, 1);
      checkOutput("rep count0", res_count0, e0);
      checkOutput("rep count1", res_count1, e1);
      checkOutput("rep class", res_class, winner(e0, e1));
      checkOutput("rep snn_input", snn_input, data);
      in_valid   = 1'b1;
      abort      = 1'($urandom);
      snn_spikes = 2'($urandom);
      res_ready  = (d == readyDelay);
      tick();
    end
    res_ready = 1'b0;
    in_valid  = 1'b0;
    abort     = 1'b0;
    checkOutput("post in_ready", in_ready, 1);
    checkOutput("post busy", busy, 0);
    checkOutput("post res_valid", res_valid, 0);
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    window_len = '0;
    abort      = 1'b0;
    snn_spikes = 2'b00;
    res_ready  = 1'b0;
    #12;
    checkResetValues("reset");
    #3 rst_n = 1'b1;
    tick();
    checkResetValues("after reset");

    // Class 0 spiking every cycle, window of 4: result in cycle 7.
    applyStimulus(8'h5A, 8'd4, 1, 0, 0, 1'b0);
    // Zero length acts as one cycle, both classes spike.
    applyStimulus(8'h11, 8'd0, 3, 0, 1, 1'b0);
    // Long window saturates class 1.
    applyStimulus(8'h77, 8'd100, 2, 0, 0, 1'b0);
    // Abort in the second RUN cycle, and another in CLEAR.
    applyStimulus(8'h3C, 8'd6, -1, C + 2, 0, 1'b0);
    applyStimulus(8'h42, 8'd5, -1, 1, 0, 1'b0);
    // Consumer stalls for 10 cycles; abort with accept in IDLE is ignored.
    applyStimulus(8'hA5, 8'd3, -1, 0, 10, 1'b1);

    // Asynchronous reset mid-RUN.
    in_valid   = 1'b1;
    in_data    = 8'hC3;
    window_len = 8'd8;
    tick();
    in_valid   = 1'b0;
    snn_spikes = 2'b11;
    tick();
    tick();
    tick();
    checkOutput("prerst snn_reset", snn_reset, 0);
    checkOutput("prerst busy", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    checkResetValues("mid reset");
    #1 rst_n = 1'b1;
    tick();
    checkOutput("rst release in_ready", in_ready, 1);
    checkOutput("rst release busy", busy, 0);
    applyStimulus(8'h96, 8'd5, -1, 0, 2, 1'b0);

    // Random transactions.
    for (int t = 0; t < 20; t++) begin
      logic [WW-1:0] wl;
      int effL;
      int ab;
      wl   = ($urandom_range(0, 7) == 0) ? WW'($urandom_range(60, 90)) : WW'($urandom_range(0, 12));
      effL = (wl == 0) ? 1 : int'(wl);
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, C + effL)) : 0;
      applyStimulus(8'($urandom), wl, -1, ab, int'($urandom_range(0, 4)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", numTests, numFails);
    $finish;
  end

endmodule

// File: doc/snn_window_scheduler.md
SNN_WINDOW_SCHEDULER -- requirements
Module: snn_window_scheduler

Interface
REQ-001 The block SHALL have parameter WINDOW_W, default 8, width of the window-length field.
REQ-002 The block SHALL have parameter CNT_W, default 6, width of each spike counter.
REQ-003 The block SHALL have parameter CLEAR_CYCLES, default 2, number of cycles SNN reset is held before each window (legal range 1..15).
REQ-004 Port clk, input, 1, single clock; all state SHALL be updated on its rising edge.
REQ-005 Port rst_n, input, 1, reset; asynchronous and active-low.
REQ-006 Port in_valid, input, 1, sample offered.
REQ-007 Port in_ready, output, 1, scheduler can accept a sample.
REQ-008 Port in_data, input, 8, raw input value for the SNN.
REQ-009 Port window_len, input, WINDOW_W, integration window in cycles; sampled only on accept.
REQ-010 Port abort, input, 1, cancels the sample in flight.
REQ-011 Port snn_reset, output, 1, active-high reset to the SNN.
REQ-012 Port snn_input, output, 8, registered value driven to the SNN rawInputValue.
REQ-013 Port snn_spikes, input, 2, SNN output spikes, one bit per class.
REQ-014 Port res_valid, output, 1, result available.
REQ-015 Port res_ready, input, 1, consumer takes the result.
REQ-016 Ports res_count0 and res_count1, output, CNT_W each, spike totals for classes 0 and 1.
REQ-017 Port res_class, output, 2: 01 means class 0 wins, 10 means class 1 wins, 00 means tie (including 0/0).
REQ-018 Port busy, output, 1, high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR, RUN and REPORT.
REQ-020 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-021 On accept (in_valid & in_ready), the block SHALL latch in_data into snn_input, latch window_len (0 treated as 1), clear both counters and move to CLEAR.
REQ-022 CLEAR SHALL last exactly CLEAR_CYCLES cycles and then move to RUN.
REQ-023 RUN SHALL last exactly the latched window length; each RUN cycle, snn_spikes[i] = 1 SHALL increment counter i, including in the last RUN cycle.
REQ-024 Each counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 snn_reset SHALL be 1 in IDLE, CLEAR and REPORT, and 0 only in RUN.
REQ-026 Latency: with the accept edge at cycle 0, res_valid SHALL first be high in cycle CLEAR_CYCLES + len + 1.
REQ-027 In REPORT, res_valid SHALL be 1 and res_count0, res_count1 and res_class SHALL be stable until res_valid & res_ready.
REQ-028 On the REPORT handshake, the FSM SHALL return to IDLE; in_ready SHALL not be asserted in the same cycle (no bypass).
REQ-029 res_class SHALL be computed from the final counts, with saturated values compared as-is (both saturated gives 00).
REQ-030 abort high in CLEAR or RUN SHALL return the FSM to IDLE on the next edge with no result and snn_input unchanged.
REQ-031 abort SHALL be ignored in IDLE and REPORT; abort together with accept in IDLE SHALL have no effect and the accept proceeds.
REQ-032 snn_spikes SHALL be ignored outside RUN.

Reset
REQ-033 While rst_n = 0, the block SHALL force state IDLE, snn_input = 0, both counters = 0, latched length = 1, res_valid = 0, snn_reset = 1, busy = 0 and res_class = 00.
REQ-034 Reset asserted mid-window SHALL discard the sample; after release the block SHALL be in IDLE with in_ready = 1.

Structure
REQ-035 Package snn_sched_pkg SHALL hold the state enum, the res_class encodings and the default CLEAR_CYCLES.
REQ-036 A sub-module snn_spike_counter (CNT_W saturating counter with clear and increment) SHALL be instantiated twice.

Verification
REQ-037 Accept in_data=0x5A, window_len=4, with class 0 spiking every RUN cycle -> res_valid first high at cycle 7, counts 4/0, class 01, snn_input=0x5A.
REQ-038 window_len=0 with both spike inputs high -> treated as length 1, counts 1/1, class 00, res_valid at cycle 4.
REQ-039 CNT_W=6, window_len=100, class 1 spiking constantly -> res_count1=63 (saturated), class 10.
REQ-040 abort pulsed in the 2nd RUN cycle -> IDLE next cycle, res_valid never rises, in_ready=1 and snn_reset=1.
REQ-041 res_ready held low for 10 cycles in REPORT -> outputs stable and in_valid not accepted; on release, in_ready rises the next cycle.
REQ-042 rst_n pulsed low mid-RUN, asynchronously between edges -> outputs take reset values immediately; the next sample runs normally.
